// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser plus one history flop for an asynchronous serial input.
// All flops preset to 1 (line idle), so no falling edge is seen coming out of reset.
module rx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic meta_q;
  logic rx_s_q;
  logic rx_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      meta_q    <= rx_i;
      rx_s_q    <= meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_s_o = rx_s_q;
  assign fall_o = rx_prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle rx_rdy per good byte, frm_err on a low stop bit.
//   state | meaning
//   IDLE  | waiting for a 1->0 transition on the synchronised line
//   START | half-bit wait, then confirm the start bit is still low
//   DATA  | sample eight data bits, LSB first, one per bit period
//   STOP  | sample the stop bit and report good byte or framing error
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  localparam int CNT_W   = $clog2(BAUD_DIV)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_rdy,
  output logic                 frm_err
);

  localparam logic [CNT_W-1:0]     HALF_M1  = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0]     FULL_M1  = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  rx_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (RX),
    .rx_s_o (rx_s),
    .fall_o (fall)
  );

  rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       baud_q, baud_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   rdy_q, rdy_d;
  logic                   err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          baud_d  = HALF_M1;
        end
      end

      START: begin
        if (baud_q == '0) begin
          // A start bit that has gone high again by mid-bit is treated as a glitch.
          if (!rx_s) begin
            state_d = DATA;
            baud_d  = FULL_M1;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_q == '0) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          baud_d  = FULL_M1;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_CNT_W'(1);
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end

      STOP: begin
        if (baud_q == '0) begin
          state_d = IDLE;
          if (rx_s) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rx_data = data_q;
  assign rx_rdy  = rdy_q;
  assign frm_err = err_q;

endmodule
